// File: rtl/multi_ultrasonic_ranger.sv
// Round-robin HC-SR04 ranger: one channel at a time, trigger -> echo width -> whole cm by a cycle sub-counter.
// Result lands the cycle after the synchronized falling edge (or timeout); no backpressure, meas_valid is a one-cycle pulse.
module multi_ultrasonic_ranger #(
  parameter int NUM_CH      = 4,
  parameter int DIST_W      = 16,
  parameter int TRIG_CYC    = 500,
  parameter int CLK_PER_CM  = 2900,
  parameter int TIMEOUT_CYC = 3000000,
  parameter int HOLDOFF_CYC = 500000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [DIST_W-1:0]        wall_thresh,
  input  logic [NUM_CH-1:0]        echo,
  output logic [NUM_CH-1:0]        trig,
  output logic [NUM_CH*DIST_W-1:0] distance,
  output logic                     meas_valid,
  output logic [2:0]               meas_ch,
  output logic [NUM_CH-1:0]        timed_out,
  output logic [NUM_CH-1:0]        wall_sense
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUB_W  = $clog2(CLK_PER_CM + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int PH_MAX = (TRIG_CYC > HOLDOFF_CYC) ? TRIG_CYC : HOLDOFF_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [DIST_W-1:0] CM_MAX = '1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t              state;
  logic [CH_W-1:0]     ch;
  logic [PH_W-1:0]     ph_cnt;
  logic [SUB_W-1:0]    sub_cnt;
  logic [DIST_W-1:0]   cm_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [NUM_CH-1:0]   echo_m, echo_s, echo_d;

  logic [2*NUM_CH-1:0] mask_rot;
  logic [CH_W:0]       sel_sum;
  logic [CH_W-1:0]     sel_ch;
  logic                sub_wrap, rise, fall, to_hit, rep_fall, rep_to;
  logic [DIST_W-1:0]   cm_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_d <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  // Rotate the mask so bit 0 is the current pointer; the lowest set offset wins.
  always_comb begin
    mask_rot = {ch_mask, ch_mask} >> ch;
    sel_sum  = {1'b0, ch};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_rot[i]) sel_sum = {1'b0, ch} + (CH_W+1)'(i);
    end
    sel_ch = (sel_sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(sel_sum - (CH_W+1)'(NUM_CH))
                                            : CH_W'(sel_sum);
  end

  assign rise     = echo_s[ch] & ~echo_d[ch];
  assign fall     = ~echo_s[ch] & echo_d[ch];
  assign sub_wrap = (sub_cnt == SUB_W'(CLK_PER_CM - 1));
  assign cm_next  = (sub_wrap && cm_cnt != CM_MAX) ? cm_cnt + 1'b1 : cm_cnt;
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  // The falling edge is counted as a high cycle and beats a simultaneous timeout.
  assign rep_fall = (state == MEASURE) && fall;
  assign rep_to   = ((state == WAIT_RISE) || (state == MEASURE)) && to_hit && !rep_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ch         <= '0;
      ph_cnt     <= '0;
      sub_cnt    <= '0;
      cm_cnt     <= '0;
      to_cnt     <= '0;
      trig       <= '0;
      distance   <= '0;
      meas_valid <= 1'b0;
      meas_ch    <= '0;
      timed_out  <= '0;
      wall_sense <= '0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && ch_mask != '0) begin
            ch     <= sel_ch;
            trig   <= NUM_CH'(1) << sel_ch;
            ph_cnt <= '0;
            state  <= TRIG;
          end
        end
        TRIG: begin
          if (ph_cnt == PH_W'(TRIG_CYC - 1)) begin
            trig   <= '0;
            to_cnt <= '0;
            state  <= WAIT_RISE;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        WAIT_RISE: begin
          to_cnt <= to_cnt + 1'b1;
          if (rise) begin
            sub_cnt <= '0;
            cm_cnt  <= '0;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          to_cnt  <= to_cnt + 1'b1;
          sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
          cm_cnt  <= cm_next;
        end
        HOLDOFF: begin
          if (ph_cnt == PH_W'(HOLDOFF_CYC - 1)) begin
            ch    <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
            state <= IDLE;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (rep_fall || rep_to) begin
        distance[ch*DIST_W +: DIST_W] <= rep_fall ? cm_next : CM_MAX;
        timed_out[ch]  <= rep_to;
        wall_sense[ch] <= rep_fall && (cm_next < wall_thresh);
        meas_valid     <= 1'b1;
        meas_ch        <= 3'(ch);
        ph_cnt         <= '0;
        state          <= HOLDOFF;
      end
    end
  end

endmodule

// File: tb/tb_multi_ultrasonic_ranger.sv
// Directed bench for multi_ultrasonic_ranger with small timing parameters and hand-computed results.
module tb_multi_ultrasonic_ranger;

  logic        clk, reset_n, enable;
  logic [3:0]  ch_mask, echo, trig, timed_out, wall_sense;
  logic [7:0]  wall_thresh;
  logic [31:0] distance;
  logic        meas_valid;
  logic [2:0]  meas_ch;

  logic        enable_sat;
  logic [3:0]  echo_sat, trig_sat, timed_out_sat, wall_sense_sat;
  logic [31:0] distance_sat;
  logic        meas_valid_sat;
  logic [2:0]  meas_ch_sat;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc = 0;
  int trig2_cnt = 0;
  int t_start, t_end;

  multi_ultrasonic_ranger #(
    .NUM_CH(4), .DIST_W(8), .TRIG_CYC(10), .CLK_PER_CM(4), .TIMEOUT_CYC(200), .HOLDOFF_CYC(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
    .wall_thresh(wall_thresh), .echo(echo), .trig(trig), .distance(distance),
    .meas_valid(meas_valid), .meas_ch(meas_ch), .timed_out(timed_out), .wall_sense(wall_sense)
  );

  multi_ultrasonic_ranger #(
    .NUM_CH(4), .DIST_W(8), .TRIG_CYC(10), .CLK_PER_CM(4), .TIMEOUT_CYC(2000), .HOLDOFF_CYC(20)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable_sat), .ch_mask(4'b0001),
    .wall_thresh(wall_thresh), .echo(echo_sat), .trig(trig_sat), .distance(distance_sat),
    .meas_valid(meas_valid_sat), .meas_ch(meas_ch_sat), .timed_out(timed_out_sat),
    .wall_sense(wall_sense_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;
  always @(negedge clk) if (trig[2]) trig2_cnt <= trig2_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] dist_of(input int c);
    return distance[c*8 +: 8];
  endfunction

  task automatic do_reset();
    enable  = 1'b0;
    echo    = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_trig_hi(output int ch);
    ch = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (trig != '0) begin
        ch = oh2idx(trig);
        break;
      end
    end
    t_start = ncyc;
    chk("trig_seen", 32'(ch >= 0), 1);
  endtask

  // Returns at the first negedge with trig low (first WAIT_RISE cycle).
  task automatic finish_trig(output int len);
    len = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (trig == '0) break;
      len++;
    end
    t_end = ncyc;
  endtask

  task automatic pulse_echo(input logic [1:0] c, input int d, input int h);
    repeat (d) @(negedge clk);
    echo[c] = 1'b1;
    repeat (h) @(negedge clk);
    echo[c] = 1'b0;
  endtask

  task automatic wait_valid(output int ch, output int lat);
    logic seen;
    seen = 1'b0;
    ch   = -1;
    lat  = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        seen = 1'b1;
        ch   = int'(meas_ch);
        lat  = ncyc - t_end;
        break;
      end
    end
    chk("valid_seen", 32'(seen), 1);
    @(negedge clk);
    chk("valid_single", 32'(meas_valid), 0);
  endtask

  initial begin
    int ch, len, lat, prev_end, t2, ntrig;
    int exp_order[4];
    logic seen;
    exp_order = '{0, 1, 3, 0};

    reset_n = 1'b1; enable = 1'b0; ch_mask = '0; wall_thresh = 8'd12; echo = '0;
    enable_sat = 1'b0; echo_sat = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_trig", trig, 0);
    chk("rst_dist", distance, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_meas_ch", meas_ch, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_wall", wall_sense, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_trig", trig, 0);

    // 1: basic measurement, 40 high cycles -> 10 cm
    do_reset();
    ch_mask = 4'b0001; wall_thresh = 8'd12; enable = 1'b1;
    wait_trig_hi(ch);
    finish_trig(len);
    chk("t1_ch", ch, 0);
    chk("t1_trig_len", len, 10);
    pulse_echo(2'd0, 20, 40);
    wait_valid(ch, lat);
    chk("t1_lat", lat, 63);
    chk("t1_meas_ch", ch, 0);
    chk("t1_dist", dist_of(0), 10);
    chk("t1_wall", wall_sense[0], 1);
    chk("t1_tmo", timed_out[0], 0);

    // 2: round-robin skipping ch2; 8 cycles -> 2 cm, equal to threshold -> no wall
    do_reset();
    ch_mask = 4'b1011; wall_thresh = 8'd2; enable = 1'b1;
    t2 = trig2_cnt;
    prev_end = 0;
    for (int k = 0; k < 4; k++) begin
      wait_trig_hi(ch);
      if (k > 0) chk("t2_gap", t_start - prev_end, 34);
      finish_trig(len);
      prev_end = t_end;
      chk("t2_order", ch, exp_order[k]);
      chk("t2_trig_len", len, 10);
      pulse_echo(2'(exp_order[k]), 2, 8);
      wait_valid(ch, lat);
      chk("t2_meas_ch", ch, exp_order[k]);
      chk("t2_dist", dist_of(exp_order[k]), 2);
      chk("t2_wall", wall_sense[exp_order[k]], 0);
    end
    chk("t2_ch2_never", trig2_cnt - t2, 0);
    chk("t2_dist2", dist_of(2), 0);

    // 3: timeout on ch1, then a good measurement clears the flag
    do_reset();
    ch_mask = 4'b0010; wall_thresh = 8'd12; enable = 1'b1;
    wait_trig_hi(ch);
    finish_trig(len);
    chk("t3_ch", ch, 1);
    wait_valid(ch, lat);
    chk("t3_lat", lat, 200);
    chk("t3_meas_ch", ch, 1);
    chk("t3_dist", dist_of(1), 8'hFF);
    chk("t3_tmo", timed_out[1], 1);
    chk("t3_wall", wall_sense[1], 0);
    wall_thresh = 8'd7;
    wait_trig_hi(ch);
    finish_trig(len);
    pulse_echo(2'd1, 5, 24);
    wait_valid(ch, lat);
    chk("t3_dist2", dist_of(1), 6);
    chk("t3_tmo_clr", timed_out[1], 0);
    chk("t3_wall2", wall_sense[1], 1);

    // 4a: echo stuck high before trigger ends -> timeout
    do_reset();
    wall_thresh = 8'd12;
    echo[0] = 1'b1;
    ch_mask = 4'b0001; enable = 1'b1;
    wait_trig_hi(ch);
    finish_trig(len);
    wait_valid(ch, lat);
    chk("t4a_lat", lat, 200);
    chk("t4a_dist", dist_of(0), 8'hFF);
    chk("t4a_tmo", timed_out[0], 1);
    echo[0] = 1'b0;

    // 4b: falling edge detected on timeout cycle 199 -> 187 cycles -> 46 cm
    do_reset();
    ch_mask = 4'b0001; enable = 1'b1;
    wait_trig_hi(ch);
    finish_trig(len);
    pulse_echo(2'd0, 10, 187);
    wait_valid(ch, lat);
    chk("t4b_lat", lat, 200);
    chk("t4b_dist", dist_of(0), 46);
    chk("t4b_tmo", timed_out[0], 0);

    // 5: 1100 cycles -> 275 cm saturates at 255
    do_reset();
    enable_sat = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (trig_sat != '0) begin seen = 1'b1; break; end
    end
    chk("t5_trig_seen", 32'(seen), 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (trig_sat == '0) break;
    end
    enable_sat = 1'b0;
    repeat (5) @(negedge clk);
    echo_sat[0] = 1'b1;
    repeat (1100) @(negedge clk);
    echo_sat[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (meas_valid_sat) begin seen = 1'b1; break; end
    end
    chk("t5_valid_seen", 32'(seen), 1);
    chk("t5_dist_sat", distance_sat[7:0], 255);
    chk("t5_tmo", timed_out_sat[0], 0);

    // 6a: reset mid-MEASURE clears results at once; reset mid-TRIG drops trig at once
    do_reset();
    ch_mask = 4'b0001; wall_thresh = 8'd12; enable = 1'b1;
    wait_trig_hi(ch);
    finish_trig(len);
    pulse_echo(2'd0, 5, 40);
    wait_valid(ch, lat);
    chk("t6_pre_dist", dist_of(0), 10);
    wait_trig_hi(ch);
    finish_trig(len);
    repeat (5) @(negedge clk);
    echo[0] = 1'b1;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_dist", distance, 0);
    chk("t6_rst_wall", wall_sense, 0);
    chk("t6_rst_tmo", timed_out, 0);
    chk("t6_rst_valid", meas_valid, 0);
    chk("t6_rst_trig", trig, 0);
    echo[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1;
    wait_trig_hi(ch);
    reset_n = 1'b0;
    #1;
    chk("t6_async_trig", trig, 0);

    // 6b: enable dropped during TRIG -> this channel completes, nothing further fires
    do_reset();
    ch_mask = 4'b0001; enable = 1'b1;
    wait_trig_hi(ch);
    enable = 1'b0;
    finish_trig(len);
    chk("t6b_trig_len", len, 10);
    pulse_echo(2'd0, 5, 20);
    wait_valid(ch, lat);
    chk("t6b_meas_ch", ch, 0);
    chk("t6b_dist", dist_of(0), 5);
    ntrig = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (trig != '0) ntrig++;
    end
    chk("t6b_no_more_trig", ntrig, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
